// File: rtl/decrypter.sv
// Iterative receive-side decrypter: ROUNDS inverse rounds, one per cycle, then a
// byte-serial CRC-8 check of the recovered plaintext, with valid/ready on both sides.
module decrypter #(
  parameter int ROUNDS = 8,
  parameter int ROT    = 3,
  parameter int KROT   = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:79] data_in,
  input  logic [0:7]  crc_in,
  input  logic [0:63] master_key,
  input  logic [0:63] baby_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:79] data_out,
  output logic        crc_ok
);

  localparam int ROT_M   = ROT % 80;
  localparam int KROT_M  = KROT % 80;
  // Decryption walks the key schedule backwards, so it starts from the last round key.
  localparam int KR_INIT = (KROT * (ROUNDS - 1)) % 80;
  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);
  localparam logic [3:0] LAST_BYTE  = 4'd9;

  typedef enum logic [1:0] {IDLE, DECRYPT, CRC, DONE} state_t;

  state_t      state_reg, state_next;
  logic [0:79] x_reg, x_next;
  logic [0:79] kr_reg, kr_next;
  logic [0:7]  crc_ref_reg, crc_ref_next;
  logic [7:0]  crc_reg, crc_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [0:79] data_out_reg, data_out_next;
  logic        crc_ok_reg, crc_ok_next;
  logic [0:79] k0;
  logic [7:0]  byte_sel;
  logic [7:0]  crc_fold;

  // Index 0 is the MSB, so a left shift moves bits toward index 0.
  function automatic logic [0:79] rotl(input logic [0:79] v, input int n);
    return (v << n) | (v >> (80 - n));
  endfunction

  function automatic logic [0:79] rotr(input logic [0:79] v, input int n);
    return (v >> n) | (v << (80 - n));
  endfunction

  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  assign k0       = {master_key, baby_key[0:15]};
  assign byte_sel = x_reg[{cnt_reg[3:0], 3'b000} +: 8];
  assign crc_fold = crc8_byte(crc_reg, byte_sel);

  always_comb begin
    state_next    = state_reg;
    x_next        = x_reg;
    kr_next       = kr_reg;
    crc_ref_next  = crc_ref_reg;
    crc_next      = crc_reg;
    cnt_next      = cnt_reg;
    data_out_next = data_out_reg;
    crc_ok_next   = crc_ok_reg;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_next       = data_in;
          crc_ref_next = crc_in;
          kr_next      = rotl(k0, KR_INIT);
          cnt_next     = 4'd0;
          state_next   = DECRYPT;
        end
      end
      DECRYPT: begin
        x_next  = rotr(x_reg, ROT_M) ^ kr_reg;
        kr_next = rotr(kr_reg, KROT_M);
        if (cnt_reg == LAST_ROUND) begin
          cnt_next   = 4'd0;
          crc_next   = 8'd0;
          state_next = CRC;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      CRC: begin
        crc_next = crc_fold;
        if (cnt_reg == LAST_BYTE) begin
          crc_ok_next   = (crc_fold == crc_ref_reg);
          data_out_next = x_reg;
          state_next    = DONE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      x_reg        <= '0;
      kr_reg       <= '0;
      crc_ref_reg  <= '0;
      crc_reg      <= '0;
      cnt_reg      <= '0;
      data_out_reg <= '0;
      crc_ok_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      x_reg        <= x_next;
      kr_reg       <= kr_next;
      crc_ref_reg  <= crc_ref_next;
      crc_reg      <= crc_next;
      cnt_reg      <= cnt_next;
      data_out_reg <= data_out_next;
      crc_ok_reg   <= crc_ok_next;
    end
  end

  assign data_out = data_out_reg;
  assign crc_ok   = crc_ok_reg;

endmodule

// File: tb/tb_decrypter.sv
// Directed testbench for decrypter: known vectors, model-encrypted round trip,
// reset abort, backpressure and back-to-back records.
`timescale 1ns/1ps
module tb_decrypter;

  localparam int ROUNDS = 8;
  localparam int ROT    = 3;
  localparam int KROT   = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [0:79] data_in = '0;
  logic [0:7]  crc_in = '0;
  logic [0:63] master_key = '0;
  logic [0:63] baby_key = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [0:79] data_out;
  logic        crc_ok;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  decrypter #(.ROUNDS(ROUNDS), .ROT(ROT), .KROT(KROT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .crc_in(crc_in), .master_key(master_key), .baby_key(baby_key),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .crc_ok(crc_ok)
  );

  // Reference model: forward cipher and bit-serial CRC.
  function automatic logic [0:79] m_rotl(input logic [0:79] v, input int n);
    logic [0:79] r;
    for (int i = 0; i < 80; i++) r[i] = v[(i + n) % 80];
    return r;
  endfunction

  function automatic logic [0:79] m_encrypt(input logic [0:79] p, input logic [0:63] mk, input logic [0:63] bk);
    logic [0:79] k0;
    logic [0:79] x;
    k0 = {mk, bk[0:15]};
    x = p;
    for (int i = 0; i < ROUNDS; i++) x = m_rotl(x ^ m_rotl(k0, (KROT * i) % 80), ROT);
    return x;
  endfunction

  function automatic logic [0:7] m_crc(input logic [0:79] p);
    logic [0:7] c;
    logic fb;
    c = '0;
    for (int i = 0; i < 80; i++) begin
      fb = c[0] ^ p[i];
      c = {c[1:7], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send(input logic [0:79] d, input logic [0:7] c, input logic [0:63] mk,
                      input logic [0:63] bk, output bit acc);
    acc = 1'b0;
    data_in = d; crc_in = c; master_key = mk; baby_key = bk; in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (in_ready) begin
        @(posedge clk);
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts edges with the accepting edge as edge 1.
  task automatic wait_out(output int edges, output bit got);
    edges = 1;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else passes++;
    checks++; if (data_out !== 80'h0) $display("FAIL reset_data_out got=%h want=0", data_out); else passes++;
    checks++; if (crc_ok !== 1'b0) $display("FAIL reset_crc_ok got=%b want=0", crc_ok); else passes++;
    $display("reset: in_ready=%b out_valid=%b data_out=%h crc_ok=%b", in_ready, out_valid, data_out, crc_ok);
  endtask

  task automatic test_zero_keys();
    logic [0:79] din[4];
    logic [0:7]  cin[4];
    logic [0:79] dexp[4];
    logic        okexp[4];
    bit acc, got;
    int edges;
    din[0] = 80'h0000_0000_0000_0100_0000; cin[0] = 8'h07; dexp[0] = 80'h0000_0000_0000_0000_0001; okexp[0] = 1'b1;
    din[1] = 80'h0000_0000_0000_0000_0001; cin[1] = 8'h00; dexp[1] = 80'h0000_0100_0000_0000_0000; okexp[1] = 1'b0;
    din[2] = 80'h0;                        cin[2] = 8'h00; dexp[2] = 80'h0;                        okexp[2] = 1'b1;
    din[3] = 80'h0;                        cin[3] = 8'h01; dexp[3] = 80'h0;                        okexp[3] = 1'b0;
    out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      send(din[v], cin[v], 64'h0, 64'h0, acc);
      wait_out(edges, got);
      checks++; if (!acc || !got || edges != 19) $display("FAIL zk%0d_latency got=%0d want=19 (acc=%b got=%b)", v, edges, acc, got); else passes++;
      checks++; if (data_out !== dexp[v]) $display("FAIL zk%0d_data got=%h want=%h", v, data_out, dexp[v]); else passes++;
      checks++; if (crc_ok !== okexp[v]) $display("FAIL zk%0d_crc_ok got=%b want=%b", v, crc_ok, okexp[v]); else passes++;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL zk%0d_release got=%b%b want=01", v, out_valid, in_ready); else passes++;
      $display("zero_keys[%0d]: din=%h crc_in=%h -> data_out=%h crc_ok=%b latency=%0d", v, din[v], cin[v], data_out, crc_ok, edges);
    end
  endtask

  task automatic test_round_trip();
    logic [0:63] mk, bk;
    logic [0:79] p, ct;
    logic [0:7]  c;
    bit acc, got;
    int edges;
    mk = 64'h7854123695478523; bk = 64'h7541689775231405; p = 80'd4568924;
    ct = m_encrypt(p, mk, bk); c = m_crc(p);
    out_ready = 1'b1;
    send(ct, c, mk, bk, acc);
    wait_out(edges, got);
    checks++; if (!acc || !got || edges != 19) $display("FAIL rt_latency got=%0d want=19 (acc=%b got=%b)", edges, acc, got); else passes++;
    checks++; if (data_out !== p) $display("FAIL rt_data got=%h want=%h", data_out, p); else passes++;
    checks++; if (crc_ok !== 1'b1) $display("FAIL rt_crc_ok got=%b want=1", crc_ok); else passes++;
    @(negedge clk);
    $display("round_trip: ct=%h crc=%h -> data_out=%h crc_ok=%b", ct, c, data_out, crc_ok);
  endtask

  task automatic test_abort_reset();
    bit acc, got, spurious;
    int edges;
    out_ready = 1'b1;
    send(80'hdead_beef_0123_4567_89ab, 8'h5a, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, acc);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL abort_in_ready got=%b want=1", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL abort_out_valid got=%b want=0", out_valid); else passes++;
    checks++; if (data_out !== 80'h0) $display("FAIL abort_data_out got=%h want=0", data_out); else passes++;
    checks++; if (crc_ok !== 1'b0) $display("FAIL abort_crc_ok got=%b want=0", crc_ok); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) spurious = 1'b1;
    end
    checks++; if (spurious) $display("FAIL abort_no_output got=1 want=0"); else passes++;
    send(80'h0000_0000_0000_0100_0000, 8'h07, 64'h0, 64'h0, acc);
    wait_out(edges, got);
    checks++; if (!acc || !got || data_out !== 80'h1 || crc_ok !== 1'b1)
      $display("FAIL abort_recover got=%h/%b want=%h/1 (acc=%b got=%b)", data_out, crc_ok, 80'h1, acc, got); else passes++;
    @(negedge clk);
    $display("abort_reset: recovered data_out=%h crc_ok=%b", data_out, crc_ok);
  endtask

  task automatic test_backpressure();
    logic [0:63] mk, bk;
    logic [0:79] p, ct;
    logic [0:7]  c;
    bit acc, got;
    int edges;
    mk = 64'h0f1e_2d3c_4b5a_6978; bk = 64'hcafe_f00d_1234_abcd; p = 80'h1234_5678_9abc_def0_1357;
    ct = m_encrypt(p, mk, bk); c = m_crc(p);
    out_ready = 1'b0;
    send(ct, c, mk, bk, acc);
    repeat (3) @(negedge clk);
    data_in = 80'hffff_ffff_ffff_ffff_ffff; crc_in = 8'hff; master_key = '1; baby_key = '1; in_valid = 1'b1;
    checks++; if (in_ready !== 1'b0) $display("FAIL bp_busy_in_ready got=%b want=0", in_ready); else passes++;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(edges, got);
    checks++; if (!acc || !got || data_out !== p || crc_ok !== 1'b1)
      $display("FAIL bp_result got=%h/%b want=%h/1 (acc=%b got=%b)", data_out, crc_ok, p, acc, got); else passes++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || data_out !== p || crc_ok !== 1'b1)
        $display("FAIL bp_hold%0d got=%b%b %h %b want=10 %h 1", i, out_valid, in_ready, data_out, crc_ok, p); else passes++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_release got=%b%b want=01", out_valid, in_ready); else passes++;
    $display("backpressure: data_out=%h crc_ok=%b held 5 cycles", data_out, crc_ok);
  endtask

  task automatic test_back_to_back();
    logic [0:79] pa, pb;
    bit acc, got;
    int edges;
    pa = 80'h0000_0000_0000_0000_0001; pb = 80'h8000_0000_0000_0000_00c3;
    out_ready = 1'b1;
    send(m_encrypt(pa, 64'h0, 64'h0), m_crc(pa), 64'h0, 64'h0, acc);
    wait_out(edges, got);
    data_in = m_encrypt(pb, 64'h0, 64'h0); crc_in = m_crc(pb); in_valid = 1'b1;
    checks++; if (!got || in_ready !== 1'b0) $display("FAIL b2b_no_same_cycle got=%b want=0 (got=%b)", in_ready, got); else passes++;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL b2b_idle got=%b%b want=01", out_valid, in_ready); else passes++;
    send(m_encrypt(pb, 64'h0, 64'h0), m_crc(pb), 64'h0, 64'h0, acc);
    wait_out(edges, got);
    checks++; if (!acc || !got || edges != 19 || data_out !== pb || crc_ok !== 1'b1)
      $display("FAIL b2b_second got=%h/%b lat=%0d want=%h/1 lat=19", data_out, crc_ok, edges, pb); else passes++;
    @(negedge clk);
    $display("back_to_back: second data_out=%h crc_ok=%b", data_out, crc_ok);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_zero_keys();
    test_round_trip();
    test_abort_reset();
    test_backpressure();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/decrypter.md
Name: decrypter

Overview:
- Iterative receive-side decrypter for the EVM vote-record link, the inverse of the combinational encrypter.
- Accepts an 80-bit ciphertext, an 8-bit CRC and two 64-bit keys over a valid/ready handshake.
- Runs ROUNDS inverse rounds, one per cycle, then checks CRC-8 over the recovered plaintext, 8 bits per cycle.
- Presents the plaintext and a pass/fail flag on a valid/ready output.

Parameters:
ROUNDS, 8, number of cipher rounds (1..16)
ROT, 3, per-round data rotation amount in bits
KROT, 7, per-round key-schedule rotation amount in bits

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  ciphertext/key bundle valid
in_ready  output  1  block can accept a bundle
data_in  input  [0:79]  ciphertext, bit 0 = MSB
crc_in  input  [0:7]  CRC sent with the record
master_key  input  [0:63]  master key
baby_key  input  [0:63]  session key
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
data_out  output  [0:79]  recovered plaintext
crc_ok  output  1  1 = computed CRC equals crc_in

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; data_out=0; crc_ok=0; all internal registers 0.
  - Reset mid-operation aborts immediately; the partial result is discarded, and no out_valid is produced for it.
- Cipher definitions (decided; the encrypter implements the forward direction):
  - rotl/rotr are 80-bit circular rotations. rotl moves bits toward index 0.
  - K0 = {master_key, baby_key[0:15]}; Ki = rotl(K0, KROT*i).
  - Encrypt round i = 0..ROUNDS-1: X = rotl(X ^ Ki, ROT).
  - CRC: CRC-8, poly 0x07, init 0x00, no reflection, no final XOR, over plaintext bits 0..79, MSB first.
- States: IDLE, DECRYPT, CRC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch data_in into X, latch crc_in, load key register KR = rotl(K0, KROT*(ROUNDS-1)), round counter=0, go to DECRYPT.
- DECRYPT, one round per cycle:
  - X <= rotr(X, ROT) ^ KR; KR <= rotr(KR, KROT); counter++.
  - After ROUNDS cycles: go to CRC, byte counter=0, crc reg=0.
- CRC:
  - Each cycle, fold X[8b:8b+7] into the crc reg (8 serial steps unrolled combinationally).
  - After 10 cycles: crc_ok <= (crc == latched crc_in); data_out <= X; go to DONE.
- DONE:
  - out_valid=1.
  - data_out and crc_ok are held stable until out_ready=1. On out_valid & out_ready: out_valid drops next cycle, state returns to IDLE.
- in_ready=0 in all states except IDLE. in_valid outside IDLE is ignored, with no side effect.
- Latency:
  - out_valid rises 1+ROUNDS+10 clock edges after the accepting edge (19 with defaults).
  - Throughput is one record per 20 cycles minimum (19 + 1 handshake edge).
- Keys are sampled only at acceptance; key changes during processing have no effect.
- out_ready=1 while not in DONE has no effect.
- Simultaneous out handshake and in_valid: the new bundle is not accepted in the same cycle. It is accepted in IDLE one cycle later.
- crc_ok is meaningful only while out_valid=1.

Test Plan:
- Reset: assert rst_n=0 mid-DECRYPT with arbitrary data -> in_ready=1, out_valid=0, data_out=0, crc_ok=0 immediately (before the next clk edge); the next bundle decrypts correctly.
- Zero keys, data_in=80'h0000_0000_0000_0100_0000, crc_in=8'h07, out_ready=1 -> out_valid exactly 19 edges after acceptance, data_out=80'h0000_0000_0000_0000_0001, crc_ok=1.
- Zero keys, data_in=80'h0000_0000_0000_0000_0001, crc_in=8'h00 -> data_out=80'h0000_0100_0000_0000_0000, crc_ok=0.
- Zero keys, data_in=0, crc_in=8'h00 -> data_out=0, crc_ok=1; repeat with crc_in=8'h01 -> crc_ok=0.
- Round trip:
  - Keys master_key=64'h7854123695478523, baby_key=64'h7541689775231405.
  - Plaintext 80'd4568924 is encrypted by the bench model, with CRC computed by the bench model.
  - Required: data_out=80'd4568924, crc_ok=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid, data_out and crc_ok stay stable, in_ready=0.
  - A second in_valid pulse during DECRYPT is ignored.
  - Raising out_ready completes the handshake, and in_ready returns to 1 the next cycle.
